phy_tx_lane_striper: RTL and testbench

- Parametrised next-generation TX striping stage of the physical layer.
- Accepts network-layer packet beats and distributes them round-robin over a runtime-programmable subset of NUM_LANES SerialLite lanes.
- Enforces per-lane credit-based flow control, with credits returned from the far-end RX over OOB.
- Keeps per-lane sent-beat statistics. Sits between network-layer TX and the SL3 TX lane interfaces.

---
 rtl/phy_tx_lane_striper_if.sv | 38 +++
 rtl/phy_tx_lane_striper.sv | 160 ++++++++++++++++
 tb/tb_phy_tx_lane_striper.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_lane_striper_if.sv
// Signal bundle between network-layer TX, the lane striper and the SL3 lane side.
// The master drives beats, lane backpressure and credit returns; the slave is the striper.
interface phy_tx_lane_striper_if #(
  parameter int NUM_LANES    = 4,
  parameter int DATA_WIDTH   = 256,
  parameter int CREDIT_WIDTH = 12,
  parameter int RET_WIDTH    = 8
);
  logic                              program_en;
  logic [NUM_LANES-1:0]              lane_mask;
  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_last;
  logic                              in_ready;
  logic [NUM_LANES-1:0]              lane_valid;
  logic [NUM_LANES*DATA_WIDTH-1:0]   lane_data;
  logic [NUM_LANES-1:0]              lane_last;
  logic [NUM_LANES-1:0]              lane_full;
  logic [NUM_LANES-1:0]              credit_ret_valid;
  logic [NUM_LANES*RET_WIDTH-1:0]    credit_ret_count;
  logic [NUM_LANES*CREDIT_WIDTH-1:0] lane_credits;
  logic [NUM_LANES*48-1:0]           lane_sent;
  logic [1:0]                        err_status;

  modport master (
    output program_en, lane_mask, in_valid, in_data, in_last,
           lane_full, credit_ret_valid, credit_ret_count,
    input  in_ready, lane_valid, lane_data, lane_last,
           lane_credits, lane_sent, err_status
  );

  modport slave (
    input  program_en, lane_mask, in_valid, in_data, in_last,
           lane_full, credit_ret_valid, credit_ret_count,
    output in_ready, lane_valid, lane_data, lane_last,
           lane_credits, lane_sent, err_status
  );
endinterface

// File: rtl/phy_tx_lane_striper.sv
// Round-robin TX striper: spreads packet beats over a programmable lane subset,
// gated by per-lane credits returned from the far end, with per-lane beat counters.
module phy_tx_lane_striper #(
  parameter int NUM_LANES    = 4,
  parameter int DATA_WIDTH   = 256,
  parameter int CREDIT_WIDTH = 12,
  parameter int INIT_CREDITS = 512,
  parameter int RET_WIDTH    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  phy_tx_lane_striper_if.slave bus
);
  localparam int PTR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SENT_W = 48;

  typedef enum logic [1:0] {UNCFG, RUN, PEND} state_e;

  state_e                  state_q;
  logic [NUM_LANES-1:0]    mask_q;
  logic [NUM_LANES-1:0]    pend_mask_q;
  logic [PTR_W-1:0]        ptr_q;
  logic                    mid_pkt_q;
  logic [1:0]              err_q;
  logic [1:0]              err_d;
  logic [NUM_LANES-1:0]    lane_valid_q;
  logic [NUM_LANES-1:0]    lane_last_q;
  logic [DATA_WIDTH-1:0]   lane_data_q [NUM_LANES];
  logic [CREDIT_WIDTH-1:0] credits_q   [NUM_LANES];
  logic [CREDIT_WIDTH-1:0] credits_d   [NUM_LANES];
  logic [CREDIT_WIDTH:0]   credit_sum  [NUM_LANES];
  logic [SENT_W-1:0]       sent_q      [NUM_LANES];
  logic [SENT_W-1:0]       sent_d      [NUM_LANES];
  logic [NUM_LANES-1:0]    ovf;
  logic [NUM_LANES-1:0]    lane_hit;

  logic                    accept;
  logic                    acc_last;
  logic                    prog_nz;
  logic                    boundary_apply;
  logic                    pend_apply;
  logic                    do_apply;
  logic                    pend_capture;
  logic [NUM_LANES-1:0]    apply_mask;

  function automatic logic [PTR_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] m);
    lowest_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = PTR_W'(i);
    end
  endfunction

  function automatic logic [PTR_W-1:0] next_lane(input logic [NUM_LANES-1:0] m,
                                                 input logic [PTR_W-1:0]     p);
    logic found;
    next_lane = lowest_lane(m);
    found     = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!found && m[i] && (i > int'(p))) begin
        next_lane = PTR_W'(i);
        found     = 1'b1;
      end
    end
  endfunction

  assign bus.in_ready = (state_q != UNCFG) && (credits_q[ptr_q] != '0) && !bus.lane_full[ptr_q];
  assign accept       = bus.in_valid && bus.in_ready;
  assign acc_last     = accept && bus.in_last;
  assign prog_nz      = bus.program_en && (bus.lane_mask != '0);

  // A new mask takes effect at once between packets; mid-packet it waits for in_last.
  assign boundary_apply = bus.program_en &&
                          ((state_q == UNCFG) || ((state_q == RUN) && (!mid_pkt_q || acc_last)));
  assign pend_apply     = (state_q == PEND) && acc_last;
  assign do_apply       = boundary_apply || pend_apply;
  assign apply_mask     = bus.program_en ? bus.lane_mask : pend_mask_q;
  assign pend_capture   = bus.program_en && (state_q == RUN) && mid_pkt_q && !acc_last;

  assign err_d = {(|ovf) || (err_q[1] && !prog_nz),
                  (do_apply && (apply_mask == '0)) || (err_q[0] && !prog_nz)};

  always_comb begin
    lane_hit = '0;
    if (accept) lane_hit[ptr_q] = 1'b1;
  end

  // Send and return are netted in one extra-wide sum so overflow is visible in the top bit.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      credit_sum[i] = {1'b0, credits_q[i]}
                    - (lane_hit[i] ? (CREDIT_WIDTH+1)'(1) : '0)
                    + (bus.credit_ret_valid[i]
                       ? (CREDIT_WIDTH+1)'(bus.credit_ret_count[i*RET_WIDTH +: RET_WIDTH])
                       : '0);
      ovf[i]        = credit_sum[i][CREDIT_WIDTH];
      credits_d[i]  = ovf[i] ? '1 : credit_sum[i][CREDIT_WIDTH-1:0];
      sent_d[i]     = sent_q[i] + (lane_hit[i] ? SENT_W'(1) : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNCFG;
      mask_q       <= '0;
      pend_mask_q  <= '0;
      ptr_q        <= '0;
      mid_pkt_q    <= 1'b0;
      err_q        <= '0;
      lane_valid_q <= '0;
      lane_last_q  <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_data_q[i] <= '0;
        credits_q[i]   <= CREDIT_WIDTH'(INIT_CREDITS);
        sent_q[i]      <= '0;
      end
    end else begin
      lane_valid_q <= lane_hit;
      lane_last_q  <= acc_last ? lane_hit : '0;
      err_q        <= err_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        credits_q[i] <= credits_d[i];
        sent_q[i]    <= sent_d[i];
      end

      if (accept) begin
        lane_data_q[ptr_q] <= bus.in_data;
        mid_pkt_q          <= !bus.in_last;
        ptr_q              <= bus.in_last ? lowest_lane(mask_q) : next_lane(mask_q, ptr_q);
      end

      if (bus.program_en) pend_mask_q <= bus.lane_mask;

      // Every packet restarts on the lowest active lane so the far end can reorder blindly.
      if (do_apply) begin
        if (apply_mask == '0) begin
          state_q   <= UNCFG;
          mask_q    <= '0;
          ptr_q     <= '0;
          mid_pkt_q <= 1'b0;
        end else begin
          state_q <= RUN;
          mask_q  <= apply_mask;
          ptr_q   <= lowest_lane(apply_mask);
        end
      end else if (pend_capture) begin
        state_q <= PEND;
      end
    end
  end

  assign bus.lane_valid = lane_valid_q;
  assign bus.lane_last  = lane_last_q;
  assign bus.err_status = err_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_out
    assign bus.lane_data[g*DATA_WIDTH +: DATA_WIDTH]       = lane_data_q[g];
    assign bus.lane_credits[g*CREDIT_WIDTH +: CREDIT_WIDTH] = credits_q[g];
    assign bus.lane_sent[g*SENT_W +: SENT_W]               = sent_q[g];
  end
endmodule

// File: tb/tb_phy_tx_lane_striper.sv
// Self-checking bench for phy_tx_lane_striper: directed scenarios plus a randomized
// stream compared against a lane-list reference model of striping, credits and errors.
module tb_phy_tx_lane_striper;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 12;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  phy_tx_lane_striper_if #(.NUM_LANES(N), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .RET_WIDTH(RW)) ifA ();
  phy_tx_lane_striper_if #(.NUM_LANES(N), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .RET_WIDTH(RW)) ifB ();

  phy_tx_lane_striper #(.NUM_LANES(N), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW),
                        .INIT_CREDITS(512), .RET_WIDTH(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifA)
  );

  phy_tx_lane_striper #(.NUM_LANES(N), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW),
                        .INIT_CREDITS(2), .RET_WIDTH(RW)) dut_lowcred (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifB)
  );

  // Reference model state (instance A only)
  int          m_state;
  logic [3:0]  m_mask;
  logic [3:0]  m_pend;
  bit          m_mid;
  int          m_beat;
  int          m_cred [N];
  logic [47:0] m_sent [N];
  logic [1:0]  m_err;
  logic        exp_ready;
  logic [3:0]  exp_valid;
  logic [3:0]  exp_last;
  logic [31:0] exp_data [N];
  logic        seen_ready;
  logic        seen_ready_b;

  function automatic int lane_for(input logic [3:0] m, input int k);
    int lanes[$];
    for (int i = 0; i < N; i++) if (m[i]) lanes.push_back(i);
    if (lanes.size() == 0) return 0;
    return lanes[k % lanes.size()];
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    onehot_idx = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < N; i++) if (v[i]) onehot_idx = i;
  endfunction

  task automatic model_reset();
    m_state = 0; m_mask = 0; m_pend = 0; m_mid = 0; m_beat = 0; m_err = 0;
    exp_ready = 0; exp_valid = 0; exp_last = 0;
    for (int i = 0; i < N; i++) begin
      m_cred[i] = 512; m_sent[i] = 0; exp_data[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [3:0] m);
    if (m == 0) begin
      m_state = 0; m_mask = 0; m_err[0] = 1'b1; m_beat = 0; m_mid = 0;
    end else begin
      m_state = 1; m_mask = m; m_beat = 0;
    end
  endtask

  task automatic model_eval();
    int lane, c;
    bit acc, acc_last, was_mid;
    lane      = lane_for(m_mask, m_beat);
    exp_ready = (m_state != 0) && (m_cred[lane] > 0) && !ifA.lane_full[lane];
    acc       = ifA.in_valid && exp_ready;
    acc_last  = acc && ifA.in_last;
    exp_valid = 0;
    exp_last  = 0;
    if (acc) begin
      exp_valid[lane] = 1'b1;
      exp_last[lane]  = ifA.in_last;
      exp_data[lane]  = ifA.in_data;
      m_sent[lane]    = m_sent[lane] + 48'd1;
    end
    if (ifA.program_en && ifA.lane_mask != 0) m_err = 2'b00;
    for (int i = 0; i < N; i++) begin
      c = m_cred[i] - ((acc && lane == i) ? 1 : 0)
        + (ifA.credit_ret_valid[i] ? int'(ifA.credit_ret_count[i*RW +: RW]) : 0);
      if (c > 4095) begin
        c = 4095;
        m_err[1] = 1'b1;
      end
      m_cred[i] = c;
    end
    was_mid = m_mid;
    if (acc) begin
      m_beat = ifA.in_last ? 0 : m_beat + 1;
      m_mid  = !ifA.in_last;
    end
    if (ifA.program_en) begin
      if (m_state == 0 || (m_state == 1 && (!was_mid || acc_last))) model_apply(ifA.lane_mask);
      else if (m_state == 1) begin
        m_pend = ifA.lane_mask; m_state = 2;
      end else begin
        m_pend = ifA.lane_mask;
        if (acc_last) model_apply(m_pend);
      end
    end else if (m_state == 2 && acc_last) model_apply(m_pend);
  endtask

  task automatic set_idle();
    ifA.program_en = 0; ifA.lane_mask = 0; ifA.in_valid = 0; ifA.in_data = 0; ifA.in_last = 0;
    ifA.lane_full = 0; ifA.credit_ret_valid = 0; ifA.credit_ret_count = 0;
    ifB.program_en = 0; ifB.lane_mask = 0; ifB.in_valid = 0; ifB.in_data = 0; ifB.in_last = 0;
    ifB.lane_full = 0; ifB.credit_ret_valid = 0; ifB.credit_ret_count = 0;
  endtask

  task automatic step();
    @(negedge clk);
    seen_ready   = ifA.in_ready;
    seen_ready_b = ifB.in_ready;
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic program_mask(input logic [3:0] m);
    ifA.program_en = 1; ifA.lane_mask = m; ifA.in_valid = 0;
    step();
    ifA.program_en = 0; ifA.lane_mask = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (ifA.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", ifA.in_ready); end
    checks++;
    if (ifA.lane_valid !== 4'b0 || ifA.lane_last !== 4'b0) begin
      failures++; $display("[TB] FAIL reset_lane_flags: got valid=%b last=%b expected 0000", ifA.lane_valid, ifA.lane_last);
    end
    checks++;
    if (ifA.lane_data !== '0) begin failures++; $display("[TB] FAIL reset_lane_data: got %h expected 0", ifA.lane_data); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ifA.lane_credits[i*CW +: CW] !== 12'd512) begin
        failures++; $display("[TB] FAIL reset_credits lane %0d: got %0d expected 512", i, ifA.lane_credits[i*CW +: CW]);
      end
    end
    checks++;
    if (ifA.lane_sent !== '0 || ifA.err_status !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_sent_err: got sent=%h err=%b expected 0/00", ifA.lane_sent, ifA.err_status);
    end
    checks++;
    if (ifB.lane_credits[CW-1:0] !== 12'd2) begin
      failures++; $display("[TB] FAIL reset_credits_lowcred: got %0d expected 2", ifB.lane_credits[CW-1:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_stripe();
    int exp_lane[7] = '{0, 1, 3, 0, 1, 3, 0};
    int obs;
    logic [31:0] d;
    do_reset();
    program_mask(4'b1011);
    for (int b = 0; b < 7; b++) begin
      d = $urandom;
      ifA.in_valid = 1; ifA.in_data = d; ifA.in_last = (b == 6);
      step();
      obs = onehot_idx(ifA.lane_valid);
      checks++;
      if (obs != exp_lane[b]) begin
        failures++; $display("[TB] FAIL stripe_lane beat %0d: got lane %0d expected lane %0d", b, obs, exp_lane[b]);
      end
      checks++;
      if (ifA.lane_data[exp_lane[b]*DW +: DW] !== d) begin
        failures++; $display("[TB] FAIL stripe_data beat %0d: got %h expected %h", b, ifA.lane_data[exp_lane[b]*DW +: DW], d);
      end
    end
    checks++;
    if (ifA.lane_last !== 4'b0001) begin failures++; $display("[TB] FAIL stripe_last: got %b expected 0001", ifA.lane_last); end
    checks++;
    if (ifA.lane_sent[0 +: 48] !== 48'd3 || ifA.lane_sent[48 +: 48] !== 48'd2 ||
        ifA.lane_sent[96 +: 48] !== 48'd0 || ifA.lane_sent[144 +: 48] !== 48'd2) begin
      failures++; $display("[TB] FAIL stripe_sent: got %0d/%0d/%0d/%0d expected 3/2/0/2", ifA.lane_sent[0 +: 48],
                           ifA.lane_sent[48 +: 48], ifA.lane_sent[96 +: 48], ifA.lane_sent[144 +: 48]);
    end
    ifA.in_valid = 1; ifA.in_data = $urandom; ifA.in_last = 0;
    step();
    checks++;
    if (ifA.lane_valid !== 4'b0001) begin failures++; $display("[TB] FAIL stripe_next_pkt: got %b expected 0001", ifA.lane_valid); end
    set_idle();
  endtask

  task automatic test_credit_stall();
    do_reset();
    ifB.program_en = 1; ifB.lane_mask = 4'b0001;
    step();
    ifB.program_en = 0; ifB.lane_mask = 0;
    for (int b = 0; b < 2; b++) begin
      ifB.in_valid = 1; ifB.in_data = $urandom; ifB.in_last = 0;
      step();
      checks++;
      if (seen_ready_b !== 1'b1 || ifB.lane_valid !== 4'b0001) begin
        failures++; $display("[TB] FAIL credit_send beat %0d: got ready=%b valid=%b expected 1/0001", b, seen_ready_b, ifB.lane_valid);
      end
    end
    ifB.in_last = 1;
    step();
    checks++;
    if (seen_ready_b !== 1'b0 || ifB.lane_valid !== 4'b0000) begin
      failures++; $display("[TB] FAIL credit_stall: got ready=%b valid=%b expected 0/0000", seen_ready_b, ifB.lane_valid);
    end
    ifB.credit_ret_valid = 4'b0001; ifB.credit_ret_count[RW-1:0] = 8'd1;
    step();
    checks++;
    if (seen_ready_b !== 1'b0 || ifB.lane_credits[CW-1:0] !== 12'd1) begin
      failures++; $display("[TB] FAIL credit_return: got ready=%b credits=%0d expected 0/1", seen_ready_b, ifB.lane_credits[CW-1:0]);
    end
    ifB.credit_ret_valid = 0; ifB.credit_ret_count = 0;
    step();
    checks++;
    if (seen_ready_b !== 1'b1 || ifB.lane_valid !== 4'b0001 || ifB.lane_last !== 4'b0001) begin
      failures++; $display("[TB] FAIL credit_resume: got ready=%b valid=%b last=%b expected 1/0001/0001",
                           seen_ready_b, ifB.lane_valid, ifB.lane_last);
    end
    checks++;
    if (ifB.lane_credits[CW-1:0] !== 12'd0) begin
      failures++; $display("[TB] FAIL credit_final: got %0d expected 0", ifB.lane_credits[CW-1:0]);
    end
    set_idle();
  endtask

  task automatic test_reprogram_mid_packet();
    int exp_lane[8] = '{0, 1, 0, 1, 1, 2, 1, 2};
    int obs;
    logic [31:0] d;
    do_reset();
    program_mask(4'b0011);
    for (int b = 0; b < 8; b++) begin
      d = $urandom;
      ifA.in_valid = 1; ifA.in_data = d; ifA.in_last = (b == 3) || (b == 7);
      ifA.program_en = (b == 1); ifA.lane_mask = (b == 1) ? 4'b0110 : 4'b0000;
      step();
      obs = onehot_idx(ifA.lane_valid);
      checks++;
      if (obs != exp_lane[b]) begin
        failures++; $display("[TB] FAIL reprogram_lane beat %0d: got lane %0d expected lane %0d", b, obs, exp_lane[b]);
      end
      checks++;
      if (ifA.lane_data[exp_lane[b]*DW +: DW] !== d) begin
        failures++; $display("[TB] FAIL reprogram_data beat %0d: got %h expected %h", b, ifA.lane_data[exp_lane[b]*DW +: DW], d);
      end
    end
    set_idle();
  endtask

  task automatic test_empty_mask();
    do_reset();
    program_mask(4'b0000);
    checks++;
    if (ifA.err_status !== 2'b01) begin failures++; $display("[TB] FAIL empty_mask_err: got %b expected 01", ifA.err_status); end
    ifA.in_valid = 1; ifA.in_data = $urandom; ifA.in_last = 0;
    step();
    checks++;
    if (seen_ready !== 1'b0 || ifA.lane_valid !== 4'b0000) begin
      failures++; $display("[TB] FAIL empty_mask_blocked: got ready=%b valid=%b expected 0/0000", seen_ready, ifA.lane_valid);
    end
    program_mask(4'b1000);
    checks++;
    if (ifA.err_status !== 2'b00) begin failures++; $display("[TB] FAIL empty_mask_clear: got %b expected 00", ifA.err_status); end
    for (int b = 0; b < 2; b++) begin
      ifA.in_valid = 1; ifA.in_data = $urandom; ifA.in_last = (b == 1);
      step();
      checks++;
      if (ifA.lane_valid !== 4'b1000) begin
        failures++; $display("[TB] FAIL single_lane beat %0d: got %b expected 1000", b, ifA.lane_valid);
      end
    end
    set_idle();
  endtask

  task automatic test_credit_saturation();
    do_reset();
    program_mask(4'b0100);
    for (int k = 0; k < 15; k++) begin
      ifA.credit_ret_valid = 4'b0100;
      ifA.credit_ret_count = 0;
      ifA.credit_ret_count[2*RW +: RW] = (k < 14) ? 8'd255 : 8'd12;
      step();
    end
    checks++;
    if (ifA.lane_credits[2*CW +: CW] !== 12'd4094 || ifA.err_status !== 2'b00) begin
      failures++; $display("[TB] FAIL sat_preload: got credits=%0d err=%b expected 4094/00",
                           ifA.lane_credits[2*CW +: CW], ifA.err_status);
    end
    ifA.in_valid = 1; ifA.in_data = $urandom; ifA.in_last = 1;
    ifA.credit_ret_count[2*RW +: RW] = 8'd5;
    step();
    checks++;
    if (seen_ready !== 1'b1 || ifA.lane_valid !== 4'b0100) begin
      failures++; $display("[TB] FAIL sat_send: got ready=%b valid=%b expected 1/0100", seen_ready, ifA.lane_valid);
    end
    checks++;
    if (ifA.lane_credits[2*CW +: CW] !== 12'd4095 || ifA.err_status !== 2'b10) begin
      failures++; $display("[TB] FAIL sat_overflow: got credits=%0d err=%b expected 4095/10",
                           ifA.lane_credits[2*CW +: CW], ifA.err_status);
    end
    set_idle();
    step();
    checks++;
    if (ifA.err_status !== 2'b10) begin failures++; $display("[TB] FAIL sat_sticky: got %b expected 10", ifA.err_status); end
  endtask

  task automatic test_stall_then_reset();
    do_reset();
    program_mask(4'b1011);
    for (int b = 0; b < 2; b++) begin
      ifA.in_valid = 1; ifA.in_data = $urandom; ifA.in_last = 0;
      step();
    end
    ifA.lane_full = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (seen_ready !== 1'b0 || ifA.lane_valid !== 4'b0000) begin
        failures++; $display("[TB] FAIL full_stall cycle %0d: got ready=%b valid=%b expected 0/0000", k, seen_ready, ifA.lane_valid);
      end
    end
    ifA.lane_full = 0;
    step();
    checks++;
    if (ifA.lane_valid !== 4'b1000) begin failures++; $display("[TB] FAIL full_resume: got %b expected 1000", ifA.lane_valid); end
    ifA.in_data = $urandom;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifA.lane_valid !== 4'b0000 || ifA.in_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL async_reset_flags: got valid=%b ready=%b expected 0000/0", ifA.lane_valid, ifA.in_ready);
    end
    checks++;
    if (ifA.lane_credits[3*CW +: CW] !== 12'd512 || ifA.lane_sent[0 +: 48] !== 48'd0) begin
      failures++; $display("[TB] FAIL async_reset_counters: got credits3=%0d sent0=%0d expected 512/0",
                           ifA.lane_credits[3*CW +: CW], ifA.lane_sent[0 +: 48]);
    end
    model_reset();
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ifA.in_valid = 1;
    step();
    checks++;
    if (seen_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_uncfg: got ready=%b expected 0", seen_ready); end
    set_idle();
  endtask

  task automatic test_random_stream();
    int len, b, guard;
    do_reset();
    program_mask(4'($urandom_range(1, 15)));
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, 6);
      b = 0;
      guard = 0;
      while (b < len && guard < 200) begin
        ifA.in_valid   = ($urandom_range(0, 3) != 0);
        ifA.in_data    = $urandom;
        ifA.in_last    = (b == len - 1);
        ifA.lane_full  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
        ifA.program_en = ($urandom_range(0, 19) == 0);
        ifA.lane_mask  = 4'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) begin
          ifA.credit_ret_valid[i]         = ($urandom_range(0, 5) == 0);
          ifA.credit_ret_count[i*RW +: RW] = 8'($urandom_range(0, 3));
        end
        step();
        if (seen_ready && ifA.in_valid) b++;
        guard++;
        checks++;
        if (seen_ready !== exp_ready) begin failures++; $display("[TB] FAIL rand_ready: got %b expected %b", seen_ready, exp_ready); end
        checks++;
        if (ifA.lane_valid !== exp_valid || ifA.lane_last !== exp_last) begin
          failures++; $display("[TB] FAIL rand_valid_last: got %b/%b expected %b/%b", ifA.lane_valid, ifA.lane_last, exp_valid, exp_last);
        end
        for (int i = 0; i < N; i++) begin
          checks++;
          if (ifA.lane_data[i*DW +: DW] !== exp_data[i] || ifA.lane_credits[i*CW +: CW] !== 12'(m_cred[i]) ||
              ifA.lane_sent[i*48 +: 48] !== m_sent[i]) begin
            failures++; $display("[TB] FAIL rand_lane %0d: got data=%h cred=%0d sent=%0d expected %h/%0d/%0d", i,
                                 ifA.lane_data[i*DW +: DW], ifA.lane_credits[i*CW +: CW], ifA.lane_sent[i*48 +: 48],
                                 exp_data[i], m_cred[i], m_sent[i]);
          end
        end
        checks++;
        if (ifA.err_status !== m_err) begin failures++; $display("[TB] FAIL rand_err: got %b expected %b", ifA.err_status, m_err); end
      end
      if (guard >= 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL rand_timeout packet %0d: got %0d beats expected %0d", p, b, len);
      end
    end
    set_idle();
  endtask

  initial begin
    $display("[TB] starting phy_tx_lane_striper bench");
    test_reset();
    test_basic_stripe();
    test_credit_stall();
    test_reprogram_mid_packet();
    test_empty_mask();
    test_credit_saturation();
    test_stall_then_reset();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
